// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parameterised UART receiver with valid/ready hand-off and error flags
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, done_q, done_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d, parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d, overrun_q, overrun_d, busy_q, busy_d;
  logic                 tick, par_odd;

  always_comb begin
    tick    = (state_q == S_START) ? (cnt_q == HALF_LAST) : (cnt_q == FULL_LAST);
    par_odd = ^shift_q ^ sync2_q;
    state_d = state_q;
    cnt_d   = (tick || state_q == S_IDLE || state_q == S_BREAK) ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = S_START;
          bit_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: if (tick) state_d = sync2_q ? S_IDLE : S_DATA;
      S_DATA: begin
        if (tick) begin
          shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BW'(1);
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          perr_d  = (PARITY == 1) ? !par_odd : par_odd;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (!sync2_q) ferr_d = 1'b1;
          bit_d = bit_q + BW'(1);
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            done_d  = 1'b1;
            state_d = sync2_q ? S_IDLE : S_BREAK;
          end
        end
      end
      S_BREAK: if (sync2_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // done_q marks the cycle after the last stop sample, when the frame is offered
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    if (done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        parity_err_d = perr_q;
        frame_err_d  = ferr_q;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      done_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= rx;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      done_q       <= done_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for three uart_rx_param configurations
module tb_uart_rx_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] rxl, rdy;
  logic [2:0] mvalid, mperr, mferr, movr, mbusy;
  logic [7:0] d0, d1;
  logic [4:0] d2;

  uart_rx_param u0 (.clk(clk), .rst(rst), .rx(rxl[0]), .rx_data(d0), .rx_valid(mvalid[0]),
    .rx_ready(rdy[0]), .parity_err(mperr[0]), .frame_err(mferr[0]), .overrun(movr[0]), .busy(mbusy[0]));
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u1 (.clk(clk), .rst(rst),
    .rx(rxl[1]), .rx_data(d1), .rx_valid(mvalid[1]), .rx_ready(rdy[1]), .parity_err(mperr[1]),
    .frame_err(mferr[1]), .overrun(movr[1]), .busy(mbusy[1]));
  uart_rx_param #(.CLKS_PER_BIT(23), .DATA_BITS(5), .PARITY(1), .STOP_BITS(1)) u2 (.clk(clk), .rst(rst),
    .rx(rxl[2]), .rx_data(d2), .rx_valid(mvalid[2]), .rx_ready(rdy[2]), .parity_err(mperr[2]),
    .frame_err(mferr[2]), .overrun(movr[2]), .busy(mbusy[2]));

  int CPB[3] = '{434, 16, 23};
  int NB[3]  = '{8, 8, 5};
  int PM[3]  = '{0, 2, 1};
  int NS[3]  = '{1, 2, 1};

  typedef struct {
    int         inst;
    logic [8:0] data;
    bit         perr;
    bit         ferr;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ovr_cnt[3] = '{0, 0, 0};
  int   exp_ovr[3] = '{0, 0, 0};
  bit   hs_prev[3] = '{0, 0, 0};

  function automatic logic [8:0] dat(input int k);
    case (k)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      default: return {4'b0, d2};
    endcase
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        if (movr[k]) ovr_cnt[k]++;
        if (hs_prev[k]) check($sformatf("valid_clear%0d", k), {31'b0, mvalid[k]}, 0);
        hs_prev[k] = mvalid[k] && rdy[k];
        if (mvalid[k] && rdy[k]) begin
          if (sbq.size() == 0 || sbq[0].inst != k) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame%0d: got %0h want none", k, dat(k));
          end else begin
            mon_e = sbq.pop_front();
            check($sformatf("data%0d", k), {23'b0, dat(k)}, {23'b0, mon_e.data});
            check($sformatf("perr%0d", k), {31'b0, mperr[k]}, {31'b0, mon_e.perr});
            check($sformatf("ferr%0d", k), {31'b0, mferr[k]}, {31'b0, mon_e.ferr});
          end
        end
      end
    end else begin
      for (int k = 0; k < 3; k++) hs_prev[k] = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int k, input logic [8:0] din, input bit pflip,
                            input bit s0, input bit s1, input bit push, input bit end_idle);
    logic [8:0] data;
    int         ones;
    bit         pbit;
    exp_t       e;
    data = din;
    ones = 0;
    for (int i = 0; i < 9; i++) begin
      if (i >= NB[k]) data[i] = 1'b0;
      ones += int'(data[i]);
    end
    pbit = (PM[k] == 2) ? ones[0] : !ones[0];
    pbit = pbit ^ pflip;
    if (push) begin
      e.inst = k;
      e.data = data;
      e.perr = (PM[k] != 0) && ((((ones + int'(pbit)) % 2) == 1) != (PM[k] == 1));
      e.ferr = !s0 || (NS[k] == 2 && !s1);
      sbq.push_back(e);
    end
    rxl[k] = 1'b0;
    cyc(CPB[k]);
    for (int i = 0; i < NB[k]; i++) begin
      rxl[k] = data[i];
      cyc(CPB[k]);
    end
    if (PM[k] != 0) begin
      rxl[k] = pbit;
      cyc(CPB[k]);
    end
    rxl[k] = s0;
    cyc(CPB[k]);
    if (NS[k] == 2) begin
      rxl[k] = s1;
      cyc(CPB[k]);
    end
    if (end_idle) begin
      rxl[k] = 1'b1;
      cyc(CPB[k] * (1 + int'($urandom_range(0, 1))));
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    logic [7:0] v;
    rst = 1'b0;
    rxl = 3'b111;
    rdy = 3'b111;
    cyc(3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_data%0d", k), {23'b0, dat(k)}, 0);
      check($sformatf("rst_valid%0d", k), {31'b0, mvalid[k]}, 0);
      check($sformatf("rst_busy%0d", k), {31'b0, mbusy[k]}, 0);
      check($sformatf("rst_flags%0d", k), {29'b0, mperr[k], mferr[k], movr[k]}, 0);
    end
    rst = 1'b1;
    cyc(5);

    send_frame(0, 9'h42, 0, 1, 1, 1, 1);
    send_frame(0, 9'h6F, 0, 1, 1, 1, 1);
    send_frame(0, 9'($urandom), 0, 1'($urandom_range(0, 1)), 1, 1, 1);
    drain();

    rxl[0] = 1'b0;
    cyc(50);
    check("false_start_busy", {31'b0, mbusy[0]}, 1);
    cyc(50);
    rxl[0] = 1'b1;
    cyc(400);
    check("false_start_idle", {30'b0, mbusy[0], mvalid[0]}, 0);

    send_frame(1, 9'h6F, 1, 1, 1, 1, 1);
    send_frame(1, 9'h6F, 0, 1, 1, 1, 1);
    drain();

    send_frame(1, 9'h3C, 0, 0, 0, 1, 0);
    cyc(10 * 16);
    check("break_busy", {31'b0, mbusy[1]}, 1);
    cyc(10 * 16);
    rxl[1] = 1'b1;
    cyc(2 * 16);
    check("break_exit", {31'b0, mbusy[1]}, 0);
    drain();

    rdy[1] = 1'b0;
    send_frame(1, 9'h11, 0, 1, 1, 1, 1);
    send_frame(1, 9'h22, 0, 1, 1, 0, 1);
    exp_ovr[1]++;
    cyc(10);
    check("ovr_held_valid", {31'b0, mvalid[1]}, 1);
    check("ovr_held_data", {23'b0, dat(1)}, 9'h11);
    rdy[1] = 1'b1;
    cyc(3);
    drain();
    check("ovr_valid_clear", {31'b0, mvalid[1]}, 0);

    v = 8'h55;
    rxl[1] = 1'b0;
    cyc(16);
    for (int i = 0; i < 3; i++) begin
      rxl[1] = v[i];
      cyc(16);
    end
    rxl[1] = v[3];
    cyc(8);
    rst = 1'b0;
    rxl[1] = 1'b1;
    cyc(2);
    check("midrst_busy", {31'b0, mbusy[1]}, 0);
    cyc(3);
    rst = 1'b1;
    cyc(32);
    check("midrst_idle", {30'b0, mbusy[1], mvalid[1]}, 0);
    send_frame(1, 9'hA5, 0, 1, 1, 1, 1);
    drain();

    for (int n = 0; n < 25; n++) begin
      send_frame(1, 9'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 4) != 0, 1, 1);
      send_frame(2, 9'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0, 1, 1, 1);
    end
    drain();
    cyc(5);

    for (int k = 0; k < 3; k++) begin
      check($sformatf("overrun_count%0d", k), ovr_cnt[k], exp_ovr[k]);
      check($sformatf("final_busy%0d", k), {31'b0, mbusy[k]}, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per bit period (legal range 16..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal range 5..9).
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame (legal values 1, 2).
REQ-005 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-008 SHALL have port rx_data  output  DATA_BITS  received word, LSB first on the line.
REQ-009 SHALL have port rx_valid  output  1  rx_data and error flags hold a frame.
REQ-010 SHALL have port rx_ready  input  1  consumer accepts the frame.
REQ-011 SHALL have port parity_err  output  1  parity mismatch for the held frame.
REQ-012 SHALL have port frame_err  output  1  a stop bit was sampled low for the held frame.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL pass rx through a 2-flop synchroniser (reset value 1); all line decisions use the synchronised value.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-017 IDLE -> START on synchronised falling edge (1 then 0); the bit counter clears to 0.
REQ-018 START: after CLKS_PER_BIT/2 cycles, sample; low -> DATA, high -> IDLE (false start, no output, no flag).
REQ-019 DATA: sample every CLKS_PER_BIT cycles from the start midpoint; shift in LSB first; after DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
REQ-020 PARITY: one sample; odd mode requires data bits plus parity bit to have odd count of ones; even mode requires an even count; mismatch latches parity_err for this frame.
REQ-021 STOP: STOP_BITS samples at CLKS_PER_BIT spacing; any low sample sets frame_err.
REQ-022 Frame completion occurs on the cycle after the last stop sample; the next state is IDLE if that sample is high, else BREAK.
REQ-023 BREAK: remain until synchronised rx is high, then IDLE; a held-low line SHALL NOT retrigger START.
REQ-024 On completion with rx_valid low: load rx_data, parity_err and frame_err, and set rx_valid in the same cycle; frames with errors are still delivered.
REQ-025 rx_valid SHALL stay high with rx_data and flags stable until a cycle with rx_valid and rx_ready both high; it clears on the next edge.
REQ-026 Completion while rx_valid is high and rx_ready is low: drop the new frame, keep the held frame, and pulse overrun for 1 cycle.
REQ-027 Completion in the same cycle as an accepting handshake (rx_valid and rx_ready both high): load the new frame, keep rx_valid high, no overrun.
REQ-028 Latency from the rx edge at the end of the last stop bit's first half to rx_valid: 2 sync cycles + 1 cycle, fixed.
REQ-029 The baud counter SHALL be sized $clog2(CLKS_PER_BIT); the bit counter SHALL be sized $clog2(DATA_BITS+1); no wrap occurs within legal ranges.
REQ-030 The receiver SHALL keep running during a pending handshake; rx_ready SHALL NOT stall line sampling.

Reset
REQ-031 While rst is low: state IDLE, sync flops 1, counters 0, rx_data 0, rx_valid/parity_err/frame_err/overrun/busy 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately with no output; after release, the first falling edge starts a new frame.

Verification
REQ-033 Defaults (8N1, 434 clk/bit): send 0x42, then 0x6F -> rx_data 0x42 then 0x6F, rx_valid each time, no error flags.
REQ-034 PARITY=2: send 0x6F with parity bit 1 -> parity_err=1, rx_data 0x6F; with parity bit 0 -> parity_err=0.
REQ-035 rx low for 100 cycles, then high -> no rx_valid, busy returns 0, state IDLE.
REQ-036 Stop bit driven low, rx held low 20 bit times -> one frame_err frame only, no second START until rx is high.
REQ-037 rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, one overrun pulse; raise rx_ready -> rx_valid clears.
REQ-038 Reset pulsed low during bit 3 of 0x55, then send 0xA5 -> only 0xA5 is delivered, no flags set.
